// File: rtl/vcve2_vload_wb_seq.sv
// ---------------------------------------------------------------------------
// vcve2_vload_wb_seq
//
// Vector-load writeback sequencer. It sits in front of the writeback stage's
// vector write port. It buffers 32-bit load response beats from the LSU in a
// small FIFO and turns them into sequential VRF word writes, starting at the
// destination register. ID-stage vector writes always win the port. When the
// load is finished, a completion pulse with an error flag goes to the
// controller.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               one-cycle pulse when a vector load is issued
//   vd_i, nbeats_i        destination register and beat count, sampled on start_i
//   busy_o                operation in progress
//   done_o, err_o         one-cycle completion pulse; err_o is qualified by done_o
//   lsu_resp_valid_i      LSU beat valid
//   lsu_resp_err_i        LSU beat carries a bus error
//   lsu_rdata_i           LSU beat data
//   lsu_resp_ready_o      beat accepted when valid and ready are both high
//   vrf_id_we_i           ID stage owns the VRF write port this cycle
//   vrf_we_o              load write request to writeback
//   vrf_waddr_o           VRF word address
//   vrf_wdata_o           VRF write data
// ---------------------------------------------------------------------------
module vcve2_vload_wb_seq #(
    parameter int VLEN       = 128,
    parameter int MAX_BEATS  = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(MAX_BEATS + 1),
    localparam int AW        = 5 + $clog2(VLEN / 32)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [4:0]    vd_i,
    input  logic [CW-1:0] nbeats_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    input  logic          lsu_resp_valid_i,
    input  logic          lsu_resp_err_i,
    input  logic [31:0]   lsu_rdata_i,
    output logic          lsu_resp_ready_o,
    input  logic          vrf_id_we_i,
    output logic          vrf_we_o,
    output logic [AW-1:0] vrf_waddr_o,
    output logic [31:0]   vrf_wdata_o
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int WOFF = $clog2(VLEN / 32);
    localparam logic [PW:0] FullCount = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] OneCount  = (PW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    vd_q, vd_d;
    logic [CW-1:0] nbeats_q, nbeats_d;
    logic [CW-1:0] rcvCnt_q, rcvCnt_d;
    logic [CW-1:0] wrCnt_q, wrCnt_d;
    logic          errSticky_q, errSticky_d;

    logic [31:0]   fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW:0]   count_q, count_d;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          fifoEmptyAfter;
    logic          push;
    logic          pop;
    logic          flush;
    logic          beatAccepted;
    logic [AW-1:0] baseAddr;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FullCount);

    // The FIFO is empty after this edge if nothing lands in it and it either
    // was already empty or its last entry is leaving through a write.
    assign fifoEmptyAfter = !push && ((count_q == '0) || ((count_q == OneCount) && pop));

    // The destination register's first word is vd * (VLEN/32); adding wrCnt in
    // the address width lets a group that runs past v31 wrap around to v0.
    assign baseAddr    = AW'(vd_q) << WOFF;
    assign vrf_waddr_o = baseAddr + AW'(wrCnt_q);
    assign vrf_wdata_o = fifoMem[rdPtr_q];

    assign beatAccepted = lsu_resp_valid_i && lsu_resp_ready_o;

    // Main control. IDLE waits for a start, ACTIVE streams beats into the
    // FIFO and writes back, ABORT drains the rest of a failed load without
    // writing, and DONE raises the one-cycle completion pulse. Ready in ACTIVE
    // comes from the full flag as it stands now, so a full FIFO takes no push
    // even when a pop happens in the same cycle. Once every expected beat has
    // arrived, later beats are refused.
    always_comb begin
        state_d          = state_q;
        vd_d             = vd_q;
        nbeats_d         = nbeats_q;
        rcvCnt_d         = rcvCnt_q;
        wrCnt_d          = wrCnt_q;
        errSticky_d      = errSticky_q;
        push             = 1'b0;
        pop              = 1'b0;
        flush            = 1'b0;
        lsu_resp_ready_o = 1'b0;
        vrf_we_o         = 1'b0;
        done_o           = 1'b0;
        err_o            = 1'b0;
        busy_o           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    errSticky_d = 1'b0;
                    if (nbeats_i != '0) begin
                        vd_d     = vd_i;
                        nbeats_d = nbeats_i;
                        rcvCnt_d = '0;
                        wrCnt_d  = '0;
                        flush    = 1'b1;
                        state_d  = ACTIVE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            ACTIVE: begin
                lsu_resp_ready_o = !fifoFull && (rcvCnt_q != nbeats_q);
                vrf_we_o         = !fifoEmpty && !vrf_id_we_i;
                pop              = vrf_we_o;
                if (pop) begin
                    wrCnt_d = wrCnt_q + CW'(1);
                end
                if (beatAccepted) begin
                    rcvCnt_d = rcvCnt_q + CW'(1);
                    if (lsu_resp_err_i) begin
                        flush       = 1'b1;
                        errSticky_d = 1'b1;
                        state_d     = (rcvCnt_q + CW'(1) == nbeats_q) ? DONE : ABORT;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (!flush && (wrCnt_d == nbeats_q) && fifoEmptyAfter) begin
                    state_d = DONE;
                end
            end

            ABORT: begin
                lsu_resp_ready_o = (rcvCnt_q != nbeats_q);
                if (beatAccepted) begin
                    rcvCnt_d = rcvCnt_q + CW'(1);
                    if (rcvCnt_q + CW'(1) == nbeats_q) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done_o      = 1'b1;
                err_o       = errSticky_q;
                errSticky_d = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping. A flush drops every entry at
    // once, and it takes precedence over a push or pop in the same cycle.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // State and bookkeeping registers. Reset puts everything back to an empty
    // idle sequencer, which also throws away any beats still buffered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            vd_q        <= '0;
            nbeats_q    <= '0;
            rcvCnt_q    <= '0;
            wrCnt_q     <= '0;
            errSticky_q <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            vd_q        <= vd_d;
            nbeats_q    <= nbeats_d;
            rcvCnt_q    <= rcvCnt_d;
            wrCnt_q     <= wrCnt_d;
            errSticky_q <= errSticky_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage. It has no reset because the occupancy count alone decides
    // which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem[wrPtr_q] <= lsu_rdata_i;
        end
    end

endmodule

// File: tb/tb_vcve2_vload_wb_seq.sv
// ---------------------------------------------------------------------------
// tb_vcve2_vload_wb_seq
//
// Scoreboard bench for the vector-load writeback sequencer. Each load pushes
// its expected VRF writes and its completion flag into queues. A monitor
// pops those queues and compares them whenever the DUT writes or signals done.
// Timing figures (done cycle, stall cycles, busy cycles) are compared against
// hand-computed constants for each directed load.
// ---------------------------------------------------------------------------
module tb_vcve2_vload_wb_seq;

    localparam int VLEN       = 128;
    localparam int MAX_BEATS  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(MAX_BEATS + 1);
    localparam int AW         = 5 + $clog2(VLEN / 32);
    localparam int NO_ERR     = 999;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [4:0]    vd_i;
    logic [CW-1:0] nbeats_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          lsu_resp_valid_i;
    logic          lsu_resp_err_i;
    logic [31:0]   lsu_rdata_i;
    logic          lsu_resp_ready_o;
    logic          vrf_id_we_i;
    logic          vrf_we_o;
    logic [AW-1:0] vrf_waddr_o;
    logic [31:0]   vrf_wdata_o;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wrExp_t;

    wrExp_t expWrQ[$];
    bit     expDoneQ[$];
    wrExp_t monExp;
    bit     monErr;
    int     pendingGood;
    int     checks;
    int     errors;

    vcve2_vload_wb_seq #(
        .VLEN       (VLEN),
        .MAX_BEATS  (MAX_BEATS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .vd_i             (vd_i),
        .nbeats_i         (nbeats_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_err_i   (lsu_resp_err_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .lsu_resp_ready_o (lsu_resp_ready_o),
        .vrf_id_we_i      (vrf_id_we_i),
        .vrf_we_o         (vrf_we_o),
        .vrf_waddr_o      (vrf_waddr_o),
        .vrf_wdata_o      (vrf_wdata_o)
    );

    // Free-running clock. Posedges fall at 5, 15, 25 and so on; negedges are
    // the sampling points.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison. Every check in the bench goes through here, so the
    // summary counters stay consistent.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor. At each negedge it checks any write or done the DUT presents
    // against the scoreboard queues. It also enforces ID priority and the
    // no-bypass rule: a write needs a good beat accepted at an earlier edge.
    always @(negedge clk) begin
        if (rst_i) begin
            pendingGood = 0;
        end else begin
            if (start_i) begin
                checkOutput("startWhileBusy", 64'(busy_o), 64'd0);
            end
            if (vrf_we_o) begin
                checkOutput("idPriority", 64'(vrf_id_we_i), 64'd0);
                checkOutput("writeLatency", 64'(pendingGood > 0), 64'd1);
                if (expWrQ.size() == 0) begin
                    checkOutput("unexpectedWrite", 64'(vrf_waddr_o), 64'h7fff_ffff);
                end else begin
                    monExp = expWrQ.pop_front();
                    checkOutput("writeAddr", 64'(vrf_waddr_o), 64'(monExp.addr));
                    checkOutput("writeData", 64'(vrf_wdata_o), 64'(monExp.data));
                end
                pendingGood--;
            end
            if (lsu_resp_valid_i && lsu_resp_ready_o) begin
                if (lsu_resp_err_i) begin
                    pendingGood = 0;
                end else begin
                    pendingGood++;
                end
            end
            if (done_o) begin
                if (expDoneQ.size() == 0) begin
                    checkOutput("unexpectedDone", 64'(done_o), 64'd0);
                end else begin
                    monErr = expDoneQ.pop_front();
                    checkOutput("doneErr", 64'(err_o), 64'(monErr));
                end
            end
        end
    end

    // Runs one directed load. It queues the expected writes (only beats before
    // an error index get written) and the expected error flag, pulses start,
    // then offers beats back to back while optionally holding the ID write
    // over a window of cycles. Cycle 0 is the cycle right after the start edge.
    task automatic applyStimulus(input logic [4:0] vd, input int n, input logic [31:0] base,
                                 input int errIdx, input int idStart, input int idLen,
                                 input int expDoneCyc, input int expStalls);
        int     i;
        int     stalls;
        int     busyCyc;
        int     doneCyc;
        logic   acc;
        wrExp_t e;
        for (int k = 0; k < n && k < errIdx; k++) begin
            e.addr = AW'((int'(vd) * 4 + k) % 128);
            e.data = base + 32'(k);
            expWrQ.push_back(e);
        end
        expDoneQ.push_back(errIdx < n);

        start_i  = 1'b1;
        vd_i     = vd;
        nbeats_i = CW'(n);
        @(posedge clk);
        #1;
        start_i = 1'b0;

        i       = 0;
        stalls  = 0;
        busyCyc = 0;
        doneCyc = -1;
        for (int c = 0; c < 200 && doneCyc < 0; c++) begin
            lsu_resp_valid_i = (i < n);
            lsu_rdata_i      = base + 32'(i);
            lsu_resp_err_i   = (i == errIdx);
            vrf_id_we_i      = (c >= idStart) && (c < idStart + idLen);
            @(negedge clk);
            acc = lsu_resp_valid_i && lsu_resp_ready_o;
            if (lsu_resp_valid_i && !lsu_resp_ready_o) stalls++;
            if (busy_o) busyCyc++;
            if (done_o) doneCyc = c;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
        vrf_id_we_i      = 1'b0;

        checkOutput("doneCycle", 64'(doneCyc), 64'(expDoneCyc));
        checkOutput("stallCycles", 64'(stalls), 64'(expStalls));
        checkOutput("busyCycles", 64'(busyCyc), 64'(expDoneCyc + 1));
        @(negedge clk);
        checkOutput("idleBusy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: reset values, streaming, ID priority, FIFO
    // backpressure, a mid-load error, a zero-length load, address wrap,
    // and a reset in the middle of a load.
    initial begin
        int   accepted;
        logic acc;
        checks           = 0;
        errors           = 0;
        pendingGood      = 0;
        rst_i            = 1'b1;
        start_i          = 1'b0;
        vd_i             = '0;
        nbeats_i         = '0;
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
        lsu_rdata_i      = '0;
        vrf_id_we_i      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetBusy", 64'(busy_o), 64'd0);
        checkOutput("resetDone", 64'(done_o), 64'd0);
        checkOutput("resetErr", 64'(err_o), 64'd0);
        checkOutput("resetWe", 64'(vrf_we_o), 64'd0);
        checkOutput("resetReady", 64'(lsu_resp_ready_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] 4-beat load, no stall");
        applyStimulus(5'd3, 4, 32'hA0, NO_ERR, 0, 0, 5, 0);

        $display("[TB] ID priority mid-stream");
        applyStimulus(5'd3, 4, 32'hA0, NO_ERR, 2, 3, 8, 0);

        $display("[TB] FIFO fill and ready backpressure");
        applyStimulus(5'd6, 6, 32'hD0, NO_ERR, 0, 6, 12, 3);

        $display("[TB] error on beat 2 of 8");
        applyStimulus(5'd5, 8, 32'h50, 2, 0, 0, 8, 0);

        $display("[TB] zero-length load");
        applyStimulus(5'd9, 0, 32'h0, NO_ERR, 0, 0, 0, 0);

        $display("[TB] address wrap past v31");
        applyStimulus(5'd31, 8, 32'hE0, NO_ERR, 0, 0, 9, 0);

        $display("[TB] reset mid-operation");
        start_i  = 1'b1;
        vd_i     = 5'd2;
        nbeats_i = CW'(4);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        vrf_id_we_i = 1'b1;
        accepted    = 0;
        for (int c = 0; c < 20 && accepted < 2; c++) begin
            lsu_resp_valid_i = 1'b1;
            lsu_rdata_i      = 32'hBB00 + 32'(accepted);
            @(negedge clk);
            acc = lsu_resp_valid_i && lsu_resp_ready_o;
            @(posedge clk);
            #1;
            if (acc) accepted++;
        end
        checkOutput("resetPreAccepted", 64'(accepted), 64'd2);
        lsu_resp_valid_i = 1'b0;
        rst_i            = 1'b1;
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        vrf_id_we_i = 1'b0;
        @(negedge clk);
        checkOutput("midResetBusy", 64'(busy_o), 64'd0);
        checkOutput("midResetWe", 64'(vrf_we_o), 64'd0);
        checkOutput("midResetDone", 64'(done_o), 64'd0);
        checkOutput("midResetReady", 64'(lsu_resp_ready_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(5'd0, 2, 32'hC0, NO_ERR, 0, 0, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("leftoverWrites", 64'(expWrQ.size()), 64'd0);
        checkOutput("leftoverDones", 64'(expDoneQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
